// File: rtl/registrador_deslocamento_if.sv
// rtl/registrador_deslocamento_if.sv - control/data bundle for the shift register
interface registrador_deslocamento_if #(
    parameter int NBITS = 4
);
    logic                         selecao;
    logic                         valor;
    logic                         entrada_serial;
    logic [NBITS-1:0]             entrada_paralela;
    logic [NBITS-1:0]             q;
    logic [$clog2(NBITS+1)-1:0]   cont;
    logic                         cheio;
    logic                         pronto;
    logic [7:0]                   seg;

    modport master (
        output selecao,
        output valor,
        output entrada_serial,
        output entrada_paralela,
        input  q,
        input  cont,
        input  cheio,
        input  pronto,
        input  seg
    );

    modport slave (
        input  selecao,
        input  valor,
        input  entrada_serial,
        input  entrada_paralela,
        output q,
        output cont,
        output cheio,
        output pronto,
        output seg
    );
endinterface

// File: rtl/registrador_deslocamento.sv
// rtl/registrador_deslocamento.sv - edge-strobed serial/parallel shift register with fill FSM and 7-segment view
module registrador_deslocamento #(
    parameter int NBITS = 4
) (
    input  logic                     clk_2,
    input  logic                     reset,
    registrador_deslocamento_if.slave bus
);
    localparam int             CW        = $clog2(NBITS + 1);
    localparam logic [CW-1:0]  CHEIO_CNT = CW'(NBITS);

    typedef enum logic [1:0] {
        VAZIO      = 2'd0,
        CARREGANDO = 2'd1,
        CHEIO      = 2'd2
    } estado_t;

    estado_t          estado;
    logic [NBITS-1:0] q_r;
    logic [CW-1:0]    cont_r;
    logic             cheio_r;
    logic             pronto_r;
    logic             valor_d;
    logic             pulso;
    logic [CW-1:0]    cont_inc;
    logic [NBITS-1:0] q_shift;
    logic [6:0]       seg7;

    // The strobe comes from a level switch, so only its rising edge may act.
    assign pulso    = bus.valor & ~valor_d;
    assign q_shift  = {bus.entrada_serial, q_r[NBITS-1:1]};
    assign cont_inc = (cont_r == CHEIO_CNT) ? CHEIO_CNT : cont_r + CW'(1);

    // Delayed copy of the strobe for rising-edge detection.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            valor_d <= 1'b0;
        end else begin
            valor_d <= bus.valor;
        end
    end

    // Fill FSM: datapath, count, full flag and completion pulse all registered together.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            estado   <= VAZIO;
            q_r      <= '0;
            cont_r   <= '0;
            cheio_r  <= 1'b0;
            pronto_r <= 1'b0;
        end else begin
            pronto_r <= 1'b0;
            if (pulso) begin
                if (bus.selecao) begin
                    // Parallel load wins from any state and drops partial serial data.
                    q_r      <= bus.entrada_paralela;
                    cont_r   <= CHEIO_CNT;
                    estado   <= CHEIO;
                    cheio_r  <= 1'b1;
                    pronto_r <= 1'b1;
                end else begin
                    q_r    <= q_shift;
                    cont_r <= cont_inc;
                    case (estado)
                        VAZIO, CARREGANDO: begin
                            if (cont_inc == CHEIO_CNT) begin
                                estado   <= CHEIO;
                                cheio_r  <= 1'b1;
                                pronto_r <= 1'b1;
                            end else begin
                                estado <= CARREGANDO;
                            end
                        end
                        CHEIO: begin
                            // Already full: keep shifting, no new completion pulse.
                            estado <= CHEIO;
                        end
                        default: begin
                            estado  <= VAZIO;
                            cheio_r <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Hex digit of the low nibble, segments gfedcba active-high.
    always_comb begin
        seg7 = 7'h00;
        case (q_r[3:0])
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            4'hF: seg7 = 7'h71;
            default: seg7 = 7'h00;
        endcase
    end

    assign bus.q      = q_r;
    assign bus.cont   = cont_r;
    assign bus.cheio  = cheio_r;
    assign bus.pronto = pronto_r;
    assign bus.seg    = {cheio_r, seg7};
endmodule

// File: tb/tb_registrador_deslocamento.sv
// tb/tb_registrador_deslocamento.sv - self-checking bench for registrador_deslocamento
module tb_registrador_deslocamento;
    localparam int N = 4;

    logic clk_2 = 1'b0;
    logic reset = 1'b1;

    registrador_deslocamento_if #(.NBITS(N)) ifc ();

    registrador_deslocamento #(.NBITS(N)) dut (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk_2 = ~clk_2;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers, full flag derived from the count.
    int m_q;
    int m_cont;
    int m_pronto;
    int m_vprev;

    logic [6:0] seg_tab [16];

    typedef struct {
        logic       sel;
        logic       val;
        logic       ser;
        logic [3:0] par;
        logic [3:0] eq;
        logic [2:0] ec;
        logic       ech;
        logic       epr;
        logic [7:0] eseg;
    } vec_t;

    vec_t tab [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] exp_seg();
        logic [7:0] s;
        s = {(m_cont == N) ? 1'b1 : 1'b0, seg_tab[m_q % 16]};
        return s;
    endfunction

    task automatic chk_model(input string tag);
        chk({tag, ".q"},      32'(ifc.q),      32'(m_q));
        chk({tag, ".cont"},   32'(ifc.cont),   32'(m_cont));
        chk({tag, ".cheio"},  32'(ifc.cheio),  (m_cont == N) ? 32'd1 : 32'd0);
        chk({tag, ".pronto"}, 32'(ifc.pronto), 32'(m_pronto));
        chk({tag, ".seg"},    32'(ifc.seg),    32'(exp_seg()));
    endtask

    // One clock edge; model updates from the inputs present at that edge, then sample.
    task automatic step();
        int pul;
        @(posedge clk_2);
        pul     = (ifc.valor && !m_vprev) ? 1 : 0;
        m_vprev = ifc.valor ? 1 : 0;
        m_pronto = 0;
        if (pul != 0) begin
            if (ifc.selecao) begin
                m_q      = int'(ifc.entrada_paralela);
                m_cont   = N;
                m_pronto = 1;
            end else begin
                m_q = (m_q >> 1) | (int'(ifc.entrada_serial) << (N - 1));
                if (m_cont < N) begin
                    m_cont = m_cont + 1;
                    if (m_cont == N) m_pronto = 1;
                end
            end
        end
        #1;
    endtask

    // Reset asserted just after an edge; outputs checked while it is held.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        m_q = 0; m_cont = 0; m_pronto = 0; m_vprev = 0;
        #1;
        chk_model(tag);
        @(negedge clk_2);
        reset = 1'b0;
    endtask

    task automatic drive(input logic sel, input logic val, input logic ser, input logic [3:0] par);
        ifc.selecao          = sel;
        ifc.valor            = val;
        ifc.entrada_serial   = ser;
        ifc.entrada_paralela = par;
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        //          sel   val   ser   par   q     cont  cheio pronto seg
        tab[0]  = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h8, 3'd1, 1'b0, 1'b0, 8'h7F};
        tab[1]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h8, 3'd1, 1'b0, 1'b0, 8'h7F};
        tab[2]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h4, 3'd2, 1'b0, 1'b0, 8'h66};
        tab[3]  = '{1'b1, 1'b0, 1'b1, 4'hF, 4'h4, 3'd2, 1'b0, 1'b0, 8'h66};
        tab[4]  = '{1'b0, 1'b1, 1'b1, 4'h0, 4'hA, 3'd3, 1'b0, 1'b0, 8'h77};
        tab[5]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'hA, 3'd3, 1'b0, 1'b0, 8'h77};
        tab[6]  = '{1'b0, 1'b1, 1'b1, 4'h0, 4'hD, 3'd4, 1'b1, 1'b1, 8'hDE};
        tab[7]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'hD, 3'd4, 1'b1, 1'b0, 8'hDE};
        tab[8]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h6, 3'd4, 1'b1, 1'b0, 8'hFD};
        tab[9]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h6, 3'd4, 1'b1, 1'b0, 8'hFD};
        tab[10] = '{1'b1, 1'b1, 1'b0, 4'hA, 4'hA, 3'd4, 1'b1, 1'b1, 8'hF7};
        tab[11] = '{1'b1, 1'b1, 1'b0, 4'h5, 4'hA, 3'd4, 1'b1, 1'b0, 8'hF7};
        tab[12] = '{1'b1, 1'b0, 1'b0, 4'h5, 4'hA, 3'd4, 1'b1, 1'b0, 8'hF7};

        drive(1'b0, 1'b0, 1'b0, 4'h0);
        @(posedge clk_2);
        #1;
        do_reset("reset");

        // Table: serial fill, saturation shift, parallel load, held strobe.
        for (int i = 0; i < 13; i++) begin
            drive(tab[i].sel, tab[i].val, tab[i].ser, tab[i].par);
            step();
            chk($sformatf("tab%0d.q", i),      32'(ifc.q),      32'(tab[i].eq));
            chk($sformatf("tab%0d.cont", i),   32'(ifc.cont),   32'(tab[i].ec));
            chk($sformatf("tab%0d.cheio", i),  32'(ifc.cheio),  32'(tab[i].ech));
            chk($sformatf("tab%0d.pronto", i), 32'(ifc.pronto), 32'(tab[i].epr));
            chk($sformatf("tab%0d.seg", i),    32'(ifc.seg),    32'(tab[i].eseg));
        end

        // Held strobe: five cycles high from empty gives exactly one shift.
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        step();
        do_reset("held.rst");
        drive(1'b0, 1'b1, 1'b1, 4'h0);
        for (int i = 0; i < 5; i++) step();
        chk("held.q", 32'(ifc.q), 32'h8);
        chk("held.cont", 32'(ifc.cont), 32'd1);
        chk_model("held");

        // Override: partial serial data dropped by a parallel load.
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        step();
        do_reset("ovr.rst");
        drive(1'b0, 1'b1, 1'b1, 4'h0); step();
        drive(1'b0, 1'b0, 1'b1, 4'h0); step();
        drive(1'b0, 1'b1, 1'b1, 4'h0); step();
        drive(1'b0, 1'b0, 1'b1, 4'h0); step();
        drive(1'b1, 1'b1, 1'b0, 4'h3); step();
        chk("ovr.q", 32'(ifc.q), 32'h3);
        chk("ovr.cont", 32'(ifc.cont), 32'd4);
        chk("ovr.cheio", 32'(ifc.cheio), 32'd1);
        chk("ovr.pronto", 32'(ifc.pronto), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 4'h3); step();
        chk("ovr.pronto_drop", 32'(ifc.pronto), 32'd0);

        // Async reset mid-fill, observed before the next rising edge.
        do_reset("async.pre");
        drive(1'b0, 1'b1, 1'b1, 4'h0); step();
        drive(1'b0, 1'b0, 1'b0, 4'h0); step();
        drive(1'b0, 1'b1, 1'b1, 4'h0); step();
        chk("async.cont_before", 32'(ifc.cont), 32'd2);
        #2;
        reset = 1'b1;
        m_q = 0; m_cont = 0; m_pronto = 0; m_vprev = 0;
        #1;
        chk("async.q", 32'(ifc.q), 32'h0);
        chk("async.cont", 32'(ifc.cont), 32'd0);
        chk("async.cheio", 32'(ifc.cheio), 32'd0);
        chk("async.seg", 32'(ifc.seg), 32'h3F);

        // Strobe already high at reset release: first edge performs one operation.
        drive(1'b0, 1'b1, 1'b1, 4'h0);
        @(negedge clk_2);
        reset = 1'b0;
        step();
        chk("relhigh.q", 32'(ifc.q), 32'h8);
        chk("relhigh.cont", 32'(ifc.cont), 32'd1);
        step();
        chk("relhigh.hold", 32'(ifc.q), 32'h8);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset("rnd.rst");
            end
            drive(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)));
            step();
            chk_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
